// File: rtl/mdiv_pkg.sv
// Shared encodings for the multiply/divide shift-register sequencer:
// command opcodes, sequencer states and datapath next-value selects.
package mdiv_pkg;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_CLR    = 3'd1;
    localparam logic [2:0] OP_LOAD   = 3'd2;
    localparam logic [2:0] OP_UNLOAD = 3'd3;
    localparam logic [2:0] OP_SHR    = 3'd4;
    localparam logic [2:0] OP_SHL    = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_UNLOAD = 2'd2,
        ST_SHIFT  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        SEL_HOLD    = 3'd0,
        SEL_CLR     = 3'd1,
        SEL_WORD_IN = 3'd2,
        SEL_ROTATE  = 3'd3,
        SEL_SHIFT   = 3'd4
    } sel_t;

endpackage

// File: rtl/mdiv_shreg_core.sv
// Operand register datapath: DW-bit register with a hold/clear/word-in/
// word-rotate/bit-shift next-value mux. Control comes from the sequencer.
module mdiv_shreg_core
    import mdiv_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  sel_t                          sel,
    input  logic                          shift_left,
    input  logic                          fill_bit,
    input  logic [WORD_W-1:0]             word_in,
    output logic [WORD_W*NUM_WORDS-1:0]   regout
);

    localparam int DW = WORD_W * NUM_WORDS;

    logic [DW-1:0] reg_r;
    logic [DW-1:0] next_s;

    // Next-value selection for the operand register
    always_comb begin
        next_s = reg_r;
        case (sel)
            SEL_HOLD:    next_s = reg_r;
            SEL_CLR:     next_s = {DW{1'b0}};
            SEL_WORD_IN: next_s = {word_in, reg_r[DW-1:WORD_W]};
            SEL_ROTATE:  next_s = {reg_r[WORD_W-1:0], reg_r[DW-1:WORD_W]};
            SEL_SHIFT: begin
                if (shift_left) begin
                    next_s = {reg_r[DW-2:0], fill_bit};
                end else begin
                    next_s = {fill_bit, reg_r[DW-1:1]};
                end
            end
            default:     next_s = reg_r;
        endcase
    end

    // Operand register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_r <= {DW{1'b0}};
        end else begin
            reg_r <= next_s;
        end
    end

    assign regout = reg_r;

endmodule

// File: rtl/mdiv_shreg_seq.sv
// Wide shift register with command sequencer for the multiply/divide datapath.
// One command per handshake on cmd_*, completion signalled by a one-cycle done.
module mdiv_shreg_seq
    import mdiv_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 8,
    parameter int CNT_W     = $clog2(WORD_W*NUM_WORDS+1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [2:0]                    cmd_op,
    input  logic [CNT_W-1:0]              cmd_cnt,
    input  logic                          fill_bit,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [WORD_W-1:0]             wr_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [WORD_W-1:0]             rd_data,
    output logic [WORD_W*NUM_WORDS-1:0]   regout,
    output logic                          msb,
    output logic                          lsb,
    output logic                          busy,
    output logic                          done
);

    localparam int                DW        = WORD_W * NUM_WORDS;
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_WORDS = CNT_W'(NUM_WORDS);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic              dir_r;
    logic              dir_nxt_s;
    logic              done_r;
    logic              done_nxt_s;
    sel_t              sel_s;

    // Sequencer state, counter, latched shift direction and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            dir_r   <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            dir_r   <= dir_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    // Next-state, counter and completion decode
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        dir_nxt_s   = dir_r;
        done_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_LOAD: begin
                            state_nxt_s = ST_LOAD;
                            cnt_nxt_s   = CNT_WORDS;
                        end
                        OP_UNLOAD: begin
                            state_nxt_s = ST_UNLOAD;
                            cnt_nxt_s   = CNT_WORDS;
                        end
                        OP_SHR, OP_SHL: begin
                            dir_nxt_s = (cmd_op == OP_SHL);
                            cnt_nxt_s = cmd_cnt;
                            // A zero-length shift completes like a NOP
                            if (cmd_cnt != CNT_ZERO) begin
                                state_nxt_s = ST_SHIFT;
                            end else begin
                                done_nxt_s = 1'b1;
                            end
                        end
                        default: done_nxt_s = 1'b1;
                    endcase
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (wr_valid) begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        state_nxt_s = ST_IDLE;
                        done_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_UNLOAD: begin
                if (rd_ready) begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        state_nxt_s = ST_IDLE;
                        done_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_UNLOAD;
                    end
                end else begin
                    state_nxt_s = ST_UNLOAD;
                end
            end
            ST_SHIFT: begin
                cnt_nxt_s = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    state_nxt_s = ST_IDLE;
                    done_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // Handshake outputs and datapath select
    always_comb begin
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        rd_valid  = 1'b0;
        sel_s     = SEL_HOLD;
        case (state_r)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid && (cmd_op == OP_CLR)) begin
                    sel_s = SEL_CLR;
                end else begin
                    sel_s = SEL_HOLD;
                end
            end
            ST_LOAD: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    sel_s = SEL_WORD_IN;
                end else begin
                    sel_s = SEL_HOLD;
                end
            end
            ST_UNLOAD: begin
                rd_valid = 1'b1;
                if (rd_ready) begin
                    sel_s = SEL_ROTATE;
                end else begin
                    sel_s = SEL_HOLD;
                end
            end
            ST_SHIFT: sel_s = SEL_SHIFT;
            default:  sel_s = SEL_HOLD;
        endcase
    end

    mdiv_shreg_core #(
        .WORD_W    (WORD_W),
        .NUM_WORDS (NUM_WORDS)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel        (sel_s),
        .shift_left (dir_r),
        .fill_bit   (fill_bit),
        .word_in    (wr_data),
        .regout     (regout)
    );

    assign rd_data = regout[WORD_W-1:0];
    assign msb     = regout[DW-1];
    assign lsb     = regout[0];
    assign busy    = (state_r != ST_IDLE);
    assign done    = done_r;

endmodule

// File: tb/tb_mdiv_shreg_seq.sv
// Self-checking bench for mdiv_shreg_seq: directed steps followed by random
// commands, all compared against a behavioural operand model.
module tb_mdiv_shreg_seq;
    import mdiv_pkg::*;

    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 8;
    localparam int DW        = WORD_W * NUM_WORDS;
    localparam int CNT_W     = $clog2(DW + 1);

    logic                 clk;
    logic                 rst_n;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [2:0]           cmd_op;
    logic [CNT_W-1:0]     cmd_cnt;
    logic                 fill_bit;
    logic                 wr_valid;
    logic                 wr_ready;
    logic [WORD_W-1:0]    wr_data;
    logic                 rd_valid;
    logic                 rd_ready;
    logic [WORD_W-1:0]    rd_data;
    logic [DW-1:0]        regout;
    logic                 msb;
    logic                 lsb;
    logic                 busy;
    logic                 done;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] model;

    mdiv_shreg_seq #(
        .WORD_W    (WORD_W),
        .NUM_WORDS (NUM_WORDS),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_cnt   (cmd_cnt),
        .fill_bit  (fill_bit),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .regout    (regout),
        .msb       (msb),
        .lsb       (lsb),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a command at a falling edge; returns at the falling edge after acceptance
    task automatic issue(input logic [2:0] op, input logic [CNT_W-1:0] cnt);
        int n = 0;
        while (!cmd_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_wait", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_cnt   = cnt;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_cnt   = CNT_W'($urandom);
    endtask

    task automatic do_simple(input logic [2:0] op);
        issue(op, CNT_W'($urandom));
        if (op == OP_CLR) model = {DW{1'b0}};
        check("simple_done", done, 1'b1);
        check("simple_busy", busy, 1'b0);
        check("simple_reg", regout, model);
        @(negedge clk);
        check("simple_done_drop", done, 1'b0);
    endtask

    task automatic do_load(input bit rnd_words, input bit b2b);
        logic [WORD_W-1:0] words [NUM_WORDS];
        logic [DW-1:0]     prev;
        logic [DW-1:0]     exp;
        for (int i = 0; i < NUM_WORDS; i++)
            words[i] = rnd_words ? WORD_W'($urandom) : WORD_W'(i + 1);
        prev = model;
        issue(OP_LOAD, CNT_W'(0));
        check("load_wr_ready", wr_ready, 1'b1);
        check("load_busy", busy, 1'b1);
        for (int k = 1; k <= NUM_WORDS; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                wr_valid = 1'b0;
                wr_data  = WORD_W'($urandom);
                @(negedge clk);
                check("load_gap_ready", wr_ready, 1'b1);
                check("load_gap_done", done, 1'b0);
            end
            wr_valid = 1'b1;
            wr_data  = words[k-1];
            @(negedge clk);
            wr_valid = 1'b0;
            exp = prev >> (k * WORD_W);
            for (int j = 0; j < k; j++)
                exp[(NUM_WORDS - k + j) * WORD_W +: WORD_W] = words[j];
            check("load_partial", regout, exp);
            check("load_done", done, (k == NUM_WORDS));
        end
        for (int i = 0; i < NUM_WORDS; i++)
            model[i * WORD_W +: WORD_W] = words[i];
        check("load_final", regout, model);
        check("load_wr_ready_low", wr_ready, 1'b0);
        if (b2b) begin
            issue(OP_CLR, CNT_W'(0));
            model = {DW{1'b0}};
            check("b2b_clr_reg", regout, model);
            check("b2b_clr_done", done, 1'b1);
        end
        @(negedge clk);
        check("load_done_drop", done, 1'b0);
    endtask

    task automatic do_unload(input bit alt);
        int  i  = 0;
        int  it = 0;
        bit  tog = 1'b1;
        issue(OP_UNLOAD, CNT_W'(0));
        while (i < NUM_WORDS && it < 400) begin
            check("unload_valid", rd_valid, 1'b1);
            check("unload_data", rd_data, model[i * WORD_W +: WORD_W]);
            check("unload_done_early", done, 1'b0);
            rd_ready = alt ? tog : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (rd_ready) i++;
            tog = !tog;
            it++;
        end
        rd_ready = 1'b0;
        check("unload_count", i, NUM_WORDS);
        check("unload_done", done, 1'b1);
        check("unload_valid_low", rd_valid, 1'b0);
        check("unload_reg", regout, model);
        @(negedge clk);
        check("unload_done_drop", done, 1'b0);
    endtask

    task automatic do_shift(input bit left, input int cnt, input int fmode, input bit poke);
        logic [DW-1:0] f;
        issue(left ? OP_SHL : OP_SHR, CNT_W'(cnt));
        if (cnt == 0) begin
            check("shift0_done", done, 1'b1);
            check("shift0_busy", busy, 1'b0);
            check("shift0_reg", regout, model);
            @(negedge clk);
            check("shift0_done_drop", done, 1'b0);
            return;
        end
        check("shift_busy", busy, 1'b1);
        check("shift_hold", regout, model);
        check("shift_done_early", done, 1'b0);
        for (int k = 1; k <= cnt; k++) begin
            fill_bit  = (fmode == 2) ? 1'($urandom_range(0, 1)) : 1'(fmode);
            cmd_valid = poke;
            cmd_op    = OP_CLR;
            f         = {DW{1'b0}};
            f[0]      = fill_bit;
            @(negedge clk);
            model = left ? ((model << 1) | f) : ((model >> 1) | (f << (DW - 1)));
            check("shift_reg", regout, model);
            check("shift_lsb", lsb, model[0]);
            check("shift_msb", msb, model[DW-1]);
            check("shift_done", done, (k == cnt));
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        check("shift_done_drop", done, 1'b0);
        check("shift_idle", busy, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_cnt   = {CNT_W{1'b0}};
        fill_bit  = 1'b0;
        wr_valid  = 1'b0;
        wr_data   = {WORD_W{1'b0}};
        rd_ready  = 1'b0;
        model     = {DW{1'b0}};
        repeat (2) @(negedge clk);
        check("rst_reg", regout, {DW{1'b0}});
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_wr_ready", wr_ready, 1'b0);
        check("rst_rd_valid", rd_valid, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed: load 1..8, shift from zero, unload, full-width shifts
        do_load(1'b0, 1'b0);
        check("load_ls_word", rd_data, 32'h0000_0001);
        do_simple(OP_CLR);
        do_shift(1'b0, 4, 1, 1'b0);
        check("shr4_top_nibble", regout[DW-1:DW-4], 4'hF);
        do_load(1'b0, 1'b0);
        do_unload(1'b1);
        do_shift(1'b0, DW, 1, 1'b0);
        do_shift(1'b1, DW, 0, 1'b0);
        do_shift(1'b1, 0, 2, 1'b0);

        // Reset in the middle of a long shift
        issue(OP_SHR, CNT_W'(100));
        for (int k = 0; k < 10; k++) begin
            logic [DW-1:0] f;
            fill_bit = 1'b1;
            f = {DW{1'b0}};
            f[0] = 1'b1;
            @(negedge clk);
            model = (model >> 1) | (f << (DW - 1));
        end
        check("pre_rst_reg", regout, model);
        rst_n = 1'b0;
        #1;
        model = {DW{1'b0}};
        check("midrst_reg", regout, model);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_cmd_ready", cmd_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_done", done, 1'b0);
        do_shift(1'b1, 3, 1, 1'b0);

        // Back-to-back CLR in the LOAD done cycle, ignored commands while busy
        do_load(1'b1, 1'b1);
        do_load(1'b1, 1'b0);
        do_shift(1'b0, 6, 2, 1'b1);
        do_simple(OP_NOP);
        do_simple(3'd6);
        do_simple(3'd7);

        // Random command mix
        for (int r = 0; r < 30; r++) begin
            case ($urandom_range(0, 7))
                0, 6, 7: do_simple(3'($urandom_range(0, 1) == 1 ? 6 + $urandom_range(0, 1) : 0));
                1:       do_simple(OP_CLR);
                2:       do_load(1'b1, 1'($urandom_range(0, 1)));
                3:       do_unload(1'b0);
                4:       do_shift(1'b0, $urandom_range(0, 300), 2, 1'($urandom_range(0, 1)));
                default: do_shift(1'b1, $urandom_range(0, 300), 2, 1'($urandom_range(0, 1)));
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdiv_shreg_seq.md
Name: mdiv_shreg_seq

Overview:
- Parametrised wide shift register with a command sequencer for the multiply/divide datapath.
- Holds a WORD_W*NUM_WORDS operand.
- Loads and unloads the operand one word per handshake on a WORD_W bus.
- Performs multi-cycle 1-bit-per-cycle right/left shifts with an externally supplied fill bit.
- Reports completion with a one-cycle done pulse, so the divider FSM issues one command and waits.

Parameters:
- WORD_W, 32, width of the load/unload word bus.
- NUM_WORDS, 8, number of words held; must be >= 2; DW = WORD_W*NUM_WORDS (localparam).
- CNT_W, $clog2(WORD_W*NUM_WORDS+1), width of the shift-count field.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  3  0 NOP, 1 CLR, 2 LOAD, 3 UNLOAD, 4 SHR, 5 SHL; 6-7 reserved.
- cmd_cnt  in  CNT_W  shift count for SHR/SHL; ignored otherwise.
- fill_bit  in  1  bit shifted in on each shift cycle; sampled every shift cycle, not latched.
- wr_valid  in  1  load word valid.
- wr_ready  out  1  high in LOAD state.
- wr_data  in  WORD_W  load word.
- rd_valid  out  1  high in UNLOAD state.
- rd_ready  in  1  unload word accepted.
- rd_data  out  WORD_W  regout[WORD_W-1:0] (LS word).
- regout  out  DW  full register contents.
- msb  out  1  regout[DW-1].
- lsb  out  1  regout[0].
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: regout=0, state IDLE, counter=0, done=0; outputs wr_ready=0, rd_valid=0, busy=0, cmd_ready=1.
- Reset mid-operation aborts immediately to these values; no done pulse.
- States: IDLE, LOAD, UNLOAD, SHIFT.
- Command accepted on cmd_valid&cmd_ready. cmd_valid while busy is ignored; no queueing.
- NOP and reserved ops:
  - No register change.
  - done=1 in the cycle after acceptance; state stays IDLE.
- CLR:
  - regout<=0 at the acceptance edge.
  - done=1 the next cycle.
- LOAD:
  - Enter LOAD with counter=NUM_WORDS.
  - Each wr handshake: regout <= {wr_data, regout[DW-1:WORD_W]} (word enters at the MS end, shifts right by WORD_W); counter decrements.
  - After NUM_WORDS handshakes the first word sits in the LS position.
  - On the final handshake edge go to IDLE with done=1 the next cycle.
  - wr_valid gaps stall with no change.
- UNLOAD:
  - rd_valid=1 and rd_data shows the LS word; counter=NUM_WORDS.
  - Each rd handshake rotates right by WORD_W: regout <= {regout[WORD_W-1:0], regout[DW-1:WORD_W]}.
  - After NUM_WORDS handshakes regout equals its value before UNLOAD.
  - Completion as for LOAD.
  - rd_ready low holds data stable.
- SHR/SHL:
  - Counter loaded with cmd_cnt.
  - cmd_cnt==0: behaves as NOP (done next cycle, no change).
  - Otherwise enter SHIFT; one 1-bit shift per cycle for exactly cmd_cnt cycles.
  - SHR: regout <= {fill_bit, regout[DW-1:1]}. SHL: regout <= {regout[DW-2:0], fill_bit}.
  - Shift edges are T+1..T+cmd_cnt for acceptance edge T. State returns to IDLE at edge T+cmd_cnt; done=1 in the following cycle.
  - cmd_cnt > DW is legal; shifting continues, and the register fully holds fill history.
- done and the return of cmd_ready=1 coincide; a new command may be accepted in the done cycle.
- msb/lsb are combinational from regout, so the divider can sample the bit shifted out on each cycle.
- The direction latch is internal; cmd_op is not required stable after acceptance.

Decomposition:
- Shared package mdiv_pkg:
  - op encodings (OP_NOP..OP_SHL);
  - state enum (ST_IDLE, ST_LOAD, ST_UNLOAD, ST_SHIFT).
- One sub-module: mdiv_shreg_core.
  - Pure datapath: DW register plus a 5-way next-value mux (hold/clear/word-in/word-rotate/bit-shift-dir), with async reset.
  - Sequencer FSM, counter and handshakes stay in the top.

Test Plan:
- Reset then LOAD of words 0x00000001..0x00000008 with wr_valid gaps -> regout = {0x8,0x7,...,0x1} (LS word 0x1), done one cycle after 8th handshake, wr_ready low after.
- SHR cnt=4 fill_bit=1 on regout=0 -> done at cycle 5 after acceptance, regout[DW-1:DW-4]=4'hF, rest 0; lsb traced each cycle.
- UNLOAD with rd_ready toggling 1,0,1... -> rd_data sequence 0x1..0x8, stable while rd_ready=0, final regout unchanged, 8 handshakes then done.
- SHL cnt=DW fill_bit=0 on all-ones -> msb=1 for DW cycles, then regout=0, done pulse; cnt=0 -> done next cycle, no change.
- rst_n asserted mid-SHR (cnt=100, after 10 shifts) -> regout=0 and busy=0 immediately, no done; next command accepted normally.
- Back-to-back: issue CLR in the done cycle of a LOAD -> accepted, regout=0 one edge later, second done pulse; cmd_valid during busy ignored.
